// File: rtl/scope_capture_ctrl_if.sv
// scope_capture_ctrl_if: sampler/display-facing signals of the capture sequencer
interface scope_capture_ctrl_if #(
  parameter int DW = 10
);
  logic [DW-1:0] wave_sample;
  logic freeze;
  logic single;
  logic arm;
  logic frame_ack;
  logic mem_we;
  logic [10:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [10:0] frame_base;
  logic frame_valid;
  logic auto_trig;
  logic [2:0] state;
  modport master (
    input wave_sample, freeze, single, arm, frame_ack,
    output mem_we, mem_waddr, mem_wdata, frame_base, frame_valid, auto_trig, state
  );
  modport slave (
    output wave_sample, freeze, single, arm, frame_ack,
    input mem_we, mem_waddr, mem_wdata, frame_base, frame_valid, auto_trig, state
  );
endinterface

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: circular pre-trigger capture, level/timeout trigger, post fill, frame handshake
module scope_capture_ctrl #(
  parameter int DEPTH = 1280,
  parameter int DW = 10,
  parameter int PRE = 320,
  parameter int LEVEL = 512,
  parameter int HYST = 8,
  parameter int HOLDOFF = 2000
) (
  input logic clk_sample,
  input logic reset,
  scope_capture_ctrl_if.master bus
);
  localparam int AW = 11;
  localparam int TW = $clog2(HOLDOFF + 1);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_A = AW'(PRE);
  localparam logic [AW-1:0] PRE_LAST = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE - 2);
  localparam logic [AW-1:0] WRAP_A = AW'(DEPTH - PRE);
  localparam logic [TW-1:0] TMAX = TW'(HOLDOFF - 1);
  localparam logic [DW-1:0] LEVEL_L = DW'(LEVEL);
  localparam logic [DW-1:0] REARM_L = DW'(LEVEL > HYST ? LEVEL - HYST : 0);
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_PRE = 3'd1, S_ARMED = 3'd2, S_POST = 3'd3, S_HOLD = 3'd4} state_t;
  state_t state_q;
  logic [AW-1:0] waddr_q, pre_cnt_q, post_cnt_q, base_next_q, mem_waddr_q, frame_base_q, base_d;
  logic [TW-1:0] tcnt_q;
  logic [DW-1:0] prev_q, mem_wdata_q;
  logic rearm_q, auto_next_q, mem_we_q, frame_valid_q, auto_trig_q;
  logic we_d, lvl_d, tmo_d;
  always_comb begin
    we_d = !bus.freeze && (state_q == S_PRE || state_q == S_ARMED || state_q == S_POST);
    lvl_d = rearm_q && prev_q < LEVEL_L && bus.wave_sample >= LEVEL_L;
    tmo_d = !bus.single && tcnt_q == TMAX;
    base_d = waddr_q >= PRE_A ? waddr_q - PRE_A : waddr_q + WRAP_A;
  end
  always_ff @(posedge clk_sample) begin
    if (reset) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      pre_cnt_q <= '0;
      post_cnt_q <= '0;
      tcnt_q <= '0;
      base_next_q <= '0;
      auto_next_q <= 1'b0;
      rearm_q <= 1'b0;
      prev_q <= '0;
      mem_we_q <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      frame_base_q <= '0;
      frame_valid_q <= 1'b0;
      auto_trig_q <= 1'b0;
    end else begin
      mem_we_q <= we_d;
      if (we_d) begin
        mem_waddr_q <= waddr_q;
        mem_wdata_q <= bus.wave_sample;
        waddr_q <= waddr_q == LAST_A ? '0 : waddr_q + 1'b1;
      end
      if (state_q == S_HOLD && bus.frame_ack) frame_valid_q <= 1'b0;
      if (!bus.freeze) begin
        prev_q <= bus.wave_sample;
        case (state_q)
          S_IDLE: if (!bus.single || bus.arm) state_q <= S_PRE;
          S_PRE: begin
            pre_cnt_q <= pre_cnt_q == PRE_LAST ? '0 : pre_cnt_q + 1'b1;
            if (pre_cnt_q == PRE_LAST) begin
              state_q <= S_ARMED;
              rearm_q <= 1'b0;
              tcnt_q <= '0;
            end
          end
          S_ARMED: begin
            if (bus.wave_sample <= REARM_L) rearm_q <= 1'b1;
            if (tcnt_q != TMAX) tcnt_q <= tcnt_q + 1'b1;
            // a level trigger outranks a simultaneous timeout
            if (lvl_d || tmo_d) begin
              base_next_q <= base_d;
              auto_next_q <= !lvl_d;
              state_q <= S_POST;
            end
          end
          S_POST: begin
            post_cnt_q <= post_cnt_q == POST_LAST ? '0 : post_cnt_q + 1'b1;
            if (post_cnt_q == POST_LAST) begin
              state_q <= S_HOLD;
              frame_base_q <= base_next_q;
              auto_trig_q <= auto_next_q;
              frame_valid_q <= 1'b1;
            end
          end
          S_HOLD: if (!frame_valid_q || bus.frame_ack) state_q <= bus.single ? S_IDLE : S_PRE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign bus.mem_we = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.frame_base = frame_base_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.auto_trig = auto_trig_q;
  assign bus.state = state_q;
endmodule
